// File: rtl/timer_pkg.sv
// Shared register map, CONTROL layout and byte-lane write helpers for the machine timer.
// The write-section indices are also used by the block RAM in the top level.
package timer_pkg;

  localparam logic [7:0] OFFSET_MTIME    = 8'h00;
  localparam logic [7:0] OFFSET_MTIMEH   = 8'h04;
  localparam logic [7:0] OFFSET_CONTROL  = 8'h08;
  localparam logic [7:0] OFFSET_CMP_BASE = 8'h10;
  localparam logic [7:0] CMP_STRIDE      = 8'h08;

  localparam int CONTROL_ENABLE_BIT  = 0;
  localparam int CONTROL_DIVISOR_LSB = 8;

  localparam int WS_BYTE0   = 0;
  localparam int WS_BYTE1   = 1;
  localparam int WS_HALF_HI = 2;

  function automatic logic [31:0] lane_mask(input logic [2:0] sections);
    logic [31:0] mask;
    mask = '0;
    if (sections[WS_BYTE0])   mask[7:0]   = 8'hFF;
    if (sections[WS_BYTE1])   mask[15:8]  = 8'hFF;
    if (sections[WS_HALF_HI]) mask[31:16] = 16'hFFFF;
    return mask;
  endfunction

  // Written lanes take the bus data; unwritten lanes keep the old register contents.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [2:0]  sections);
    logic [31:0] mask;
    mask = lane_mask(sections);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Holds the CONTROL enable and divisor and produces one tick every divisor+1 enabled cycles.
// Loading new CONTROL contents restarts the divide count from zero.
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk24,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      enable_next,
  input  logic [PRESCALE_WIDTH-1:0] divisor_next,
  output logic                      enable,
  output logic [PRESCALE_WIDTH-1:0] divisor,
  output logic                      tick
);

  logic                      enable_reg;
  logic [PRESCALE_WIDTH-1:0] divisor_reg;
  logic [PRESCALE_WIDTH-1:0] count_reg;

  assign enable  = enable_reg;
  assign divisor = divisor_reg;
  assign tick    = enable_reg && (count_reg == divisor_reg);

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      enable_reg  <= 1'b1;
      divisor_reg <= '0;
      count_reg   <= '0;
    end else if (load) begin
      enable_reg  <= enable_next;
      divisor_reg <= divisor_next;
      count_reg   <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else if (enable_reg) begin
      count_reg <= count_reg + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_mmio.sv
// Memory-mapped machine timer: prescaled mtime counter, per-channel compare interrupts,
// and a one-cycle read port whose MTIME lo read snapshots the upper counter bits.
module timer_mmio
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h80000000,
  parameter int          NUM_CHANNELS   = 1,
  parameter int          TIME_WIDTH     = 64,
  parameter int          PRESCALE_WIDTH = 8
) (
  input  logic                    clk24,
  input  logic                    reset,
  input  logic [31:0]             memory_address,
  input  logic [31:0]             memory_write_value,
  input  logic [2:0]              memory_write_sections,
  output logic [31:0]             read_value,
  output logic                    read_selected,
  output logic [NUM_CHANNELS-1:0] timer_interrupt
);

  localparam int          HI_WIDTH     = TIME_WIDTH - 32;
  localparam logic [31:0] WINDOW_BYTES = 32'(OFFSET_CMP_BASE) + 32'(CMP_STRIDE) * 32'(NUM_CHANNELS);

  logic [31:0] offset;
  logic [7:0]  reg_offset;
  logic        hit;
  logic        write_en;
  logic        snapshot;

  // Addresses below the base wrap to huge offsets, so one unsigned compare decodes the window.
  assign offset     = memory_address - BASE_ADDRESS;
  assign reg_offset = {offset[7:2], 2'b00};
  assign hit        = offset < WINDOW_BYTES;
  assign write_en   = hit && (memory_write_sections != 3'b000);
  assign snapshot   = hit && !write_en && (reg_offset == OFFSET_MTIME);

  logic                      enable;
  logic [PRESCALE_WIDTH-1:0] divisor;
  logic                      tick;
  logic                      control_write;
  logic [31:0]               control_read;
  logic [31:0]               control_written;

  always_comb begin
    control_read = '0;
    control_read[CONTROL_ENABLE_BIT] = enable;
    control_read[CONTROL_DIVISOR_LSB +: PRESCALE_WIDTH] = divisor;
  end

  assign control_write   = write_en && (reg_offset == OFFSET_CONTROL);
  assign control_written = merge_lanes(control_read, memory_write_value, memory_write_sections);

  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk24       (clk24),
    .reset       (reset),
    .load        (control_write),
    .enable_next (control_written[CONTROL_ENABLE_BIT]),
    .divisor_next(control_written[CONTROL_DIVISOR_LSB +: PRESCALE_WIDTH]),
    .enable      (enable),
    .divisor     (divisor),
    .tick        (tick)
  );

  logic [TIME_WIDTH-1:0] mtime_reg;
  logic [HI_WIDTH-1:0]   shadow_hi_reg;
  logic [63:0]           mtime_ext;
  logic [63:0]           mtime_written;
  logic                  mtime_lo_write;
  logic                  mtime_hi_write;

  assign mtime_ext      = 64'(mtime_reg);
  assign mtime_lo_write = write_en && (reg_offset == OFFSET_MTIME);
  assign mtime_hi_write = write_en && (reg_offset == OFFSET_MTIMEH);
  assign mtime_written  = {
    mtime_hi_write ? merge_lanes(mtime_ext[63:32], memory_write_value, memory_write_sections) : mtime_ext[63:32],
    mtime_lo_write ? merge_lanes(mtime_ext[31:0],  memory_write_value, memory_write_sections) : mtime_ext[31:0]
  };

  // A software write to either half wins over the tick for the whole counter.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      mtime_reg     <= '0;
      shadow_hi_reg <= '0;
    end else begin
      if (mtime_lo_write || mtime_hi_write) begin
        mtime_reg <= mtime_written[TIME_WIDTH-1:0];
      end else if (tick) begin
        mtime_reg <= mtime_reg + TIME_WIDTH'(1);
      end
      if (snapshot) begin
        shadow_hi_reg <= mtime_reg[TIME_WIDTH-1:32];
      end
    end
  end

  logic [NUM_CHANNELS-1:0][31:0] cmp_lo_word;
  logic [NUM_CHANNELS-1:0][31:0] cmp_hi_word;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_channel
    localparam logic [7:0] LO_OFFSET = 8'(OFFSET_CMP_BASE + CMP_STRIDE * gi);

    logic [TIME_WIDTH-1:0] cmp_reg;
    logic                  irq_reg;
    logic                  lo_write;
    logic                  hi_write;
    logic [63:0]           cmp_ext;
    logic [63:0]           cmp_written;

    assign cmp_ext     = 64'(cmp_reg);
    assign lo_write    = write_en && (reg_offset == LO_OFFSET);
    assign hi_write    = write_en && (reg_offset == LO_OFFSET + 8'd4);
    assign cmp_written = {
      hi_write ? merge_lanes(cmp_ext[63:32], memory_write_value, memory_write_sections) : cmp_ext[63:32],
      lo_write ? merge_lanes(cmp_ext[31:0],  memory_write_value, memory_write_sections) : cmp_ext[31:0]
    };

    // The compare uses pre-edge values, so a new CMP only shows on the following edge.
    always_ff @(posedge clk24 or posedge reset) begin
      if (reset) begin
        cmp_reg <= '1;
        irq_reg <= 1'b0;
      end else begin
        if (lo_write || hi_write) begin
          cmp_reg <= cmp_written[TIME_WIDTH-1:0];
        end
        irq_reg <= (mtime_reg >= cmp_reg);
      end
    end

    assign cmp_lo_word[gi]     = cmp_ext[31:0];
    assign cmp_hi_word[gi]     = cmp_ext[63:32];
    assign timer_interrupt[gi] = irq_reg;
  end

  logic [31:0] read_next;

  always_comb begin
    read_next = '0;
    case (reg_offset)
      OFFSET_MTIME:   read_next = mtime_ext[31:0];
      OFFSET_MTIMEH:  read_next = 32'(shadow_hi_reg);
      OFFSET_CONTROL: read_next = control_read;
      default:        read_next = '0;
    endcase
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (reg_offset == 8'(OFFSET_CMP_BASE + CMP_STRIDE * ch))      read_next = cmp_lo_word[ch];
      if (reg_offset == 8'(OFFSET_CMP_BASE + CMP_STRIDE * ch + 4))  read_next = cmp_hi_word[ch];
    end
    if (!hit) read_next = '0;
  end

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      read_value    <= '0;
      read_selected <= 1'b0;
    end else begin
      read_value    <= read_next;
      read_selected <= hit;
    end
  end

endmodule

// File: tb/tb_timer_mmio.sv
// Self-checking bench for timer_mmio with two channels: directed steps followed by random bus
// traffic, every cycle compared against an arithmetic model of the timer.
module tb_timer_mmio;

  localparam logic [31:0] BASE = 32'h80000000;

  logic        clk24 = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] memory_address = '0;
  logic [31:0] memory_write_value = '0;
  logic [2:0]  memory_write_sections = '0;
  logic [31:0] read_value;
  logic        read_selected;
  logic [1:0]  timer_interrupt;

  timer_mmio #(
    .BASE_ADDRESS(BASE),
    .NUM_CHANNELS(2)
  ) dut (
    .clk24                (clk24),
    .reset                (reset),
    .memory_address       (memory_address),
    .memory_write_value   (memory_write_value),
    .memory_write_sections(memory_write_sections),
    .read_value           (read_value),
    .read_selected        (read_selected),
    .timer_interrupt      (timer_interrupt)
  );

  always #5 clk24 = ~clk24;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] m_time;
  logic [63:0] m_cmp [2];
  logic [31:0] m_shadow;
  bit          m_en;
  int unsigned m_div;
  int unsigned m_pcnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_time   = '0;
    m_cmp[0] = '1;
    m_cmp[1] = '1;
    m_shadow = '0;
    m_en     = 1'b1;
    m_div    = 0;
    m_pcnt   = 0;
  endtask

  // One bus cycle: predict from pre-edge model state, clock, then compare and advance the model.
  task automatic bus(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] secs,
                     input string tag);
    logic [31:0] off, rexp, ctrl, mask, merged;
    logic [63:0] old_time;
    logic [1:0]  iexp;
    logic [2:0]  word;
    bit          hit, wr, tick;
    int unsigned pnext;
    off  = addr - BASE;
    hit  = off < 32'h20;
    word = off[4:2];
    wr   = hit && (secs != 3'b000);
    tick = m_en && (m_pcnt == m_div);
    ctrl = (m_div << 8) | 32'(m_en);
    rexp = '0;
    if (hit) begin
      case (word)
        3'd0: rexp = m_time[31:0];
        3'd1: rexp = m_shadow;
        3'd2: rexp = ctrl;
        3'd4: rexp = m_cmp[0][31:0];
        3'd5: rexp = m_cmp[0][63:32];
        3'd6: rexp = m_cmp[1][31:0];
        3'd7: rexp = m_cmp[1][63:32];
        default: rexp = '0;
      endcase
    end
    for (int c = 0; c < 2; c++) iexp[c] = (m_time >= m_cmp[c]);

    memory_address        = addr;
    memory_write_value    = data;
    memory_write_sections = secs;
    @(posedge clk24);
    #1;

    mask = '0;
    if (secs[0]) mask[7:0]   = 8'hFF;
    if (secs[1]) mask[15:8]  = 8'hFF;
    if (secs[2]) mask[31:16] = 16'hFFFF;
    old_time = m_time;
    if (hit && !wr && word == 3'd0) m_shadow = old_time[63:32];
    if (wr && word == 3'd2) pnext = 0;
    else if (tick)          pnext = 0;
    else if (m_en)          pnext = m_pcnt + 1;
    else                    pnext = m_pcnt;
    m_pcnt = pnext;
    if (wr) begin
      case (word)
        3'd0: m_time[31:0]    = (m_time[31:0]    & ~mask) | (data & mask);
        3'd1: m_time[63:32]   = (m_time[63:32]   & ~mask) | (data & mask);
        3'd2: begin
          merged = (ctrl & ~mask) | (data & mask);
          m_en   = merged[0];
          m_div  = 32'(merged[15:8]);
        end
        3'd4: m_cmp[0][31:0]  = (m_cmp[0][31:0]  & ~mask) | (data & mask);
        3'd5: m_cmp[0][63:32] = (m_cmp[0][63:32] & ~mask) | (data & mask);
        3'd6: m_cmp[1][31:0]  = (m_cmp[1][31:0]  & ~mask) | (data & mask);
        3'd7: m_cmp[1][63:32] = (m_cmp[1][63:32] & ~mask) | (data & mask);
        default: ;
      endcase
    end
    if (!(wr && word <= 3'd1) && tick) m_time = m_time + 64'd1;

    check({tag, "/read_selected"}, 64'(read_selected), 64'(hit));
    check({tag, "/read_value"}, 64'(read_value), 64'(rexp));
    check({tag, "/timer_interrupt"}, 64'(timer_interrupt), 64'(iexp));
    if (tag != "idle")
      $display("txn %s addr=%h data=%h secs=%b read=%h sel=%0d irq=%b",
               tag, addr, data, secs, read_value, read_selected, timer_interrupt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(32'h0, 32'h0, 3'b000, "idle");
  endtask

  initial begin
    logic [31:0] a, b, addr, data;
    logic [2:0]  secs;
    int          rise0, rise1, r;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk24);
    #1;
    check("reset/read_value", 64'(read_value), 64'h0);
    check("reset/read_selected", 64'(read_selected), 64'h0);
    check("reset/timer_interrupt", 64'(timer_interrupt), 64'h0);
    reset = 1'b0;

    // Free-running count with divisor 0: read MTIME lo in the tenth cycle
    idle(9);
    bus(BASE, 32'h0, 3'b000, "rd_mtime_lo");
    check("cycle10_window", 64'((read_value >= 32'd9) && (read_value <= 32'd11)), 64'h1);

    // Divisor 3: exactly ten ticks in forty cycles, then frozen while disabled
    bus(BASE + 32'h8, 32'h0000_0301, 3'b111, "wr_control");
    bus(BASE + 32'h8, 32'h0, 3'b000, "rd_control");
    bus(BASE, 32'h0, 3'b000, "rd_mtime_lo");
    a = read_value;
    idle(39);
    bus(BASE, 32'h0, 3'b000, "rd_mtime_lo");
    b = read_value;
    check("div3_advance", 64'(b - a), 64'd10);
    bus(BASE + 32'h8, 32'h0000_0300, 3'b111, "wr_control");
    bus(BASE, 32'h0, 3'b000, "rd_mtime_lo");
    a = read_value;
    idle(19);
    bus(BASE, 32'h0, 3'b000, "rd_mtime_lo");
    check("disabled_frozen", 64'(read_value), 64'(a));

    // Carry into the high word and snapshot consistency
    bus(BASE + 32'h8, 32'h0000_0001, 3'b111, "wr_control");
    bus(BASE, 32'hFFFF_FFFF, 3'b111, "wr_mtime_lo");
    bus(BASE + 32'h4, 32'h0, 3'b111, "wr_mtime_hi");
    idle(1);
    bus(BASE, 32'h0, 3'b000, "rd_mtime_lo");
    check("carry_lo", 64'(read_value), 64'h0);
    idle(3);
    bus(BASE + 32'h4, 32'h0, 3'b000, "rd_mtime_hi");
    check("carry_shadow_hi", 64'(read_value), 64'h1);

    // Two compare channels at 100 and 50
    bus(BASE + 32'h14, 32'h0, 3'b111, "wr_cmp0_hi");
    bus(BASE + 32'h10, 32'd100, 3'b111, "wr_cmp0_lo");
    bus(BASE + 32'h1C, 32'h0, 3'b111, "wr_cmp1_hi");
    bus(BASE + 32'h18, 32'd50, 3'b111, "wr_cmp1_lo");
    bus(BASE + 32'h4, 32'h0, 3'b111, "wr_mtime_hi");
    bus(BASE, 32'h0, 3'b111, "wr_mtime_lo");
    rise0 = 0;
    rise1 = 0;
    for (int k = 1; k <= 110; k++) begin
      idle(1);
      if (timer_interrupt[1] && rise1 == 0) rise1 = k;
      if (timer_interrupt[0] && rise0 == 0) rise0 = k;
    end
    check("irq1_rise_cycle", 64'(rise1), 64'd51);
    check("irq0_rise_cycle", 64'(rise0), 64'd101);
    bus(BASE + 32'h18, 32'hFFFF_FFFF, 3'b111, "wr_cmp1_lo");
    check("irq1_held_on_write_edge", 64'(timer_interrupt[1]), 64'h1);
    idle(1);
    check("irq1_fall", 64'(timer_interrupt[1]), 64'h0);
    bus(BASE + 32'h1C, 32'hFFFF_FFFF, 3'b111, "wr_cmp1_hi");

    // Byte-lane write and write-over-tick priority
    bus(BASE + 32'h10, 32'h0000_AB00, 3'b010, "wr_cmp0_byte1");
    bus(BASE + 32'h10, 32'h0, 3'b000, "rd_cmp0_lo");
    check("cmp0_byte1_merge", 64'(read_value), 64'h0000_AB64);
    bus(BASE, 32'h0000_1234, 3'b111, "wr_mtime_lo");
    bus(BASE, 32'h0, 3'b000, "rd_mtime_lo");
    check("write_beats_tick", 64'(read_value), 64'h0000_1234);

    // Asynchronous reset mid-count with an interrupt asserted
    bus(BASE + 32'h4, 32'h1, 3'b111, "wr_mtime_hi");
    idle(2);
    check("irq0_high_before_reset", 64'(timer_interrupt[0]), 64'h1);
    reset = 1'b1;
    #2;
    check("async_reset/read_value", 64'(read_value), 64'h0);
    check("async_reset/read_selected", 64'(read_selected), 64'h0);
    check("async_reset/timer_interrupt", 64'(timer_interrupt), 64'h0);
    #2;
    reset = 1'b0;
    model_reset();
    bus(BASE + 32'h10, 32'h0, 3'b000, "rd_cmp0_lo");
    check("reset_cmp0_lo", 64'(read_value), 64'hFFFF_FFFF);
    bus(BASE + 32'h1C, 32'h0, 3'b000, "rd_cmp1_hi");
    check("reset_cmp1_hi", 64'(read_value), 64'hFFFF_FFFF);
    bus(32'h8000_0100, 32'h0, 3'b000, "rd_outside");
    check("outside_window", 64'(read_selected), 64'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       addr = BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
      else if (r == 8) addr = BASE + 32'h20;
      else             addr = BASE - 32'd4;
      secs = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      data = $urandom;
      // keep the divisor small so the counter keeps moving
      if (r == 2) data[15:8] = 8'($urandom_range(0, 3));
      bus(addr, data, secs, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
